// File: rtl/burst_read_engine_pkg.sv
// ---------------------------------------------------------------------------
// burst_read_engine_pkg
// Shared definitions for the burst read engine:
//   - state_e          : engine control states (IDLE / ISSUE / DRAIN)
//   - DEF_ADDR_WIDTH   : default memory line address width (30)
//   - DEF_DATA_WIDTH   : default memory line width in bits (512)
//   - BURST_MAX        : burst length encoded by cmd_len == 0 (256)
//   - burst_len()      : expands the 8-bit command length to a 9-bit count
// ---------------------------------------------------------------------------
package burst_read_engine_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int DEF_ADDR_WIDTH = 30;
    localparam int DEF_DATA_WIDTH = 512;
    localparam int BURST_MAX      = 256;

    // A zero length field stands for the maximum burst.
    function automatic logic [8:0] burst_len(input logic [7:0] len);
        return (len == 8'd0) ? 9'(BURST_MAX) : {1'b0, len};
    endfunction

endpackage

// File: rtl/burst_read_engine_fifo.sv
// ---------------------------------------------------------------------------
// synchronousFifo
// Single-clock return buffer for the burst read engine. First-word
// fall-through: o_data shows the head entry whenever o_empty is low.
// Ports:
//   clk, rstb   : clock, asynchronous active-low reset (pointers/count only)
//   i_push      : write i_data (ignored when full)
//   i_pop       : drop head entry (ignored when empty)
//   o_data      : head entry
//   o_empty     : no entries stored
//   o_count     : number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module synchronousFifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic [AW:0]      o_count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != FULL_COUNT);
    assign w_pop   = i_pop && (r_count != '0);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/burst_read_engine.sv
// ---------------------------------------------------------------------------
// burst_read_engine
// Accepts a burst command (start line, line count), issues one read request
// per line to a memory port under a credit limit sized to the return buffer,
// buffers the in-order returns and streams them to a consumer with a last
// marker on the final line of the burst.
// Ports:
//   clk, rstb                         : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : burst command (len 0 = 256 lines)
//   mem_raddr/mem_rvalid/mem_ready    : read request to memory
//   mem_rdata/mem_rddata_valid        : read return from memory
//   out_data/out_valid/out_ready/out_last : line stream to consumer
//   err_unexpected                    : sticky, return seen with none pending
//   stat_bursts/stat_stall_cycles     : statistics counters
// Configuration macro: BURST_READ_STATS_EN enables the statistics counters;
// when undefined both statistics outputs are tied to zero.
// ---------------------------------------------------------------------------
module burst_read_engine
    import burst_read_engine_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    output logic                  mem_rvalid,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rddata_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  err_unexpected,
    output logic [31:0]           stat_bursts,
    output logic [31:0]           stat_stall_cycles
);

    localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

    state_e                r_state;
    logic                  r_alive;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [8:0]            r_remaining;
    logic [8:0]            r_total;
    logic [8:0]            r_out_cnt;
    logic [CW-1:0]         r_outstanding;
    logic                  r_err;

    logic [CW-1:0]         w_fifo_count;
    logic                  w_fifo_empty;
    logic                  w_credit_ok;
    logic                  w_accept;
    logic                  w_issue;
    logic                  w_ret;
    logic                  w_err;
    logic                  w_pop;

    // r_alive holds cmd_ready low until the first clock after reset release.
    assign cmd_ready = (r_state == IDLE) && r_alive;
    assign w_accept  = cmd_valid && cmd_ready;

    // Lines in flight plus lines buffered never exceed the buffer depth, so
    // every return always finds room.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, w_fifo_count}) < CREDIT_MAX;
    assign w_issue     = (r_state == ISSUE) && mem_ready && w_credit_ok
                         && (r_remaining != 9'd0);

    assign mem_rvalid = w_issue;
    assign mem_raddr  = r_addr;

    // A return with nothing pending (e.g. left over from before a reset) is
    // flagged and dropped instead of being buffered.
    assign w_ret = mem_rddata_valid && (r_outstanding != '0);
    assign w_err = mem_rddata_valid && (r_outstanding == '0);

    assign out_valid = !w_fifo_empty;
    assign w_pop     = out_valid && out_ready;
    assign out_last  = out_valid && (r_out_cnt == (r_total - 9'd1));

    assign err_unexpected = r_err;

    synchronousFifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstb    (rstb),
        .i_push  (w_ret),
        .i_data  (mem_rdata),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state       <= IDLE;
            r_alive       <= 1'b0;
            r_addr        <= '0;
            r_remaining   <= '0;
            r_total       <= '0;
            r_out_cnt     <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_err   <= r_err | w_err;

            if (w_pop) begin
                r_out_cnt <= r_out_cnt + 9'd1;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr      <= cmd_addr;
                        r_remaining <= burst_len(cmd_len);
                        r_total     <= burst_len(cmd_len);
                        r_out_cnt   <= '0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        // Address wraps naturally at the top of the line space.
                        r_addr      <= r_addr + ADDR_WIDTH'(1);
                        r_remaining <= r_remaining - 9'd1;
                        if (r_remaining == 9'd1) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && out_last) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // Issue and return in the same cycle cancel out.
            case ({w_issue, w_ret})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

`ifdef BURST_READ_STATS_EN
    logic [31:0] r_stat_bursts;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_stat_bursts <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_accept) begin
                r_stat_bursts <= r_stat_bursts + 32'd1;
            end
            // A stall is a cycle with lines still to request but no request.
            if ((r_state == ISSUE) && (r_remaining != 9'd0) && !w_issue) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_bursts       = r_stat_bursts;
    assign stat_stall_cycles = r_stat_stall;
`else
    assign stat_bursts       = 32'd0;
    assign stat_stall_cycles = 32'd0;
`endif

endmodule
